// File: rtl/dmem_bridge.sv
// dmem_bridge: multi-cycle data-memory stage between execute and write-back.
// Turns a load/store from the pipeline into a req/ack bus transaction and
// holds the pipeline via stall until the transaction completes. It also
// raises memEx for misaligned, out-of-range or timed-out accesses.
module dmem_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] CAPACITY = 32'h0000_ffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] exeOut,
    input  logic [31:0] rd2,
    output logic [31:0] memOut,
    output logic        stall,
    output logic        memEx,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    input  logic        busAck,
    input  logic [31:0] busRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen during the last BUSY cycle before the access is abandoned.
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    state_t      state_r,     state_nxt_s;
    logic [7:0]  cnt_r,       cnt_nxt_s;
    logic [31:0] mem_out_r,   mem_out_nxt_s;
    logic        mem_ex_r,    mem_ex_nxt_s;
    logic        bus_req_r,   bus_req_nxt_s;
    logic        bus_we_r,    bus_we_nxt_s;
    logic [31:0] bus_addr_r,  bus_addr_nxt_s;
    logic [31:0] bus_wdata_r, bus_wdata_nxt_s;

    logic        access_s;
    logic        valid_s;
    logic        last_cycle_s;

    assign access_s     = MemRead | MemWrite;
    assign valid_s      = (exeOut[1:0] == 2'b00) && (exeOut <= CAPACITY);
    assign last_cycle_s = (cnt_r == TO_LAST_C);

    // Stall is combinational so the PC is held in the very cycle an access appears;
    // it is gated by reset so an abandoned access releases the pipeline at once.
    assign stall = ~reset & (((state_r == IDLE) & access_s) | (state_r == BUSY));

    assign memOut   = mem_out_r;
    assign memEx    = mem_ex_r;
    assign busReq   = bus_req_r;
    assign busWe    = bus_we_r;
    assign busAddr  = bus_addr_r;
    assign busWData = bus_wdata_r;

    // Next-state and next-register logic; every register holds unless a transition updates it.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        mem_out_nxt_s   = mem_out_r;
        mem_ex_nxt_s    = mem_ex_r;
        bus_req_nxt_s   = bus_req_r;
        bus_we_nxt_s    = bus_we_r;
        bus_addr_nxt_s  = bus_addr_r;
        bus_wdata_nxt_s = bus_wdata_r;

        case (state_r)
            IDLE: begin
                if (access_s) begin
                    if (valid_s) begin
                        // MemWrite wins when both controls are set.
                        bus_addr_nxt_s  = exeOut;
                        bus_wdata_nxt_s = rd2;
                        bus_we_nxt_s    = MemWrite;
                        bus_req_nxt_s   = 1'b1;
                        cnt_nxt_s       = 8'd0;
                        state_nxt_s     = BUSY;
                    end else begin
                        mem_ex_nxt_s  = 1'b1;
                        mem_out_nxt_s = 32'd0;
                        state_nxt_s   = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                cnt_nxt_s = cnt_r + 8'd1;
                if (busAck) begin
                    // An ack in the final allowed cycle still completes normally.
                    if (!bus_we_r) begin
                        mem_out_nxt_s = busRData;
                    end else begin
                        mem_out_nxt_s = mem_out_r;
                    end
                    bus_req_nxt_s = 1'b0;
                    mem_ex_nxt_s  = 1'b0;
                    state_nxt_s   = DONE;
                end else if (last_cycle_s) begin
                    bus_req_nxt_s = 1'b0;
                    mem_out_nxt_s = 32'd0;
                    mem_ex_nxt_s  = 1'b1;
                    state_nxt_s   = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                // Inputs are ignored here so the committing instruction is not re-issued.
                mem_ex_nxt_s = 1'b0;
                state_nxt_s  = IDLE;
            end
            default: begin
                bus_req_nxt_s = 1'b0;
                mem_ex_nxt_s  = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any bus transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            mem_out_r   <= 32'd0;
            mem_ex_r    <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mem_out_r   <= mem_out_nxt_s;
            mem_ex_r    <= mem_ex_nxt_s;
            bus_req_r   <= bus_req_nxt_s;
            bus_we_r    <= bus_we_nxt_s;
            bus_addr_r  <= bus_addr_nxt_s;
            bus_wdata_r <= bus_wdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a driver issues loads/stores and acts as
// the bus slave, pushing the expected outcome of each access; a monitor on the
// falling edge checks bus behaviour, stall length and the DONE-cycle result.
module tb_dmem_bridge;

    localparam int          TO  = 16;
    localparam logic [31:0] CAP = 32'h0000_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] exeOut, rd2;
    logic [31:0] memOut;
    logic        stall, memEx;
    logic        busReq, busWe;
    logic [31:0] busAddr, busWData;
    logic        busAck;
    logic [31:0] busRData;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          breq;   // expected busReq-high cycles
        int          stl;    // expected stall-high cycles
        logic [31:0] mout;   // memOut in DONE
        logic        mex;    // memEx in DONE
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem = 32'd0;

    dmem_bridge #(.TIMEOUT(TO), .CAPACITY(CAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .exeOut   (exeOut),
        .rd2      (rd2),
        .memOut   (memOut),
        .stall    (stall),
        .memEx    (memEx),
        .busReq   (busReq),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busAck   (busAck),
        .busRData (busRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor state
    int   stall_len = 0;
    int   breq_len  = 0;
    int   last_breq = 0;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            stall_len  = 0;
            breq_len   = 0;
            last_breq  = 0;
            prev_stall = 1'b0;
            sb.delete();
        end else begin
            logic done_now;
            done_now = prev_stall && !stall;
            if (busReq) begin
                if (sb.size() == 0) begin
                    chk("orphan_busreq", 32'd1, 32'd0);
                end else begin
                    chk("bus_we",    {31'd0, busWe}, {31'd0, sb[0].we});
                    chk("bus_addr",  busAddr,  sb[0].addr);
                    chk("bus_wdata", busWData, sb[0].wdata);
                end
                breq_len++;
            end else if (breq_len != 0) begin
                last_breq = breq_len;
                breq_len  = 0;
            end
            if (stall) stall_len++;
            if (done_now) begin
                if (sb.size() == 0) begin
                    chk("orphan_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("stall_len",  32'(stall_len), 32'(e.stl));
                    chk("busreq_len", 32'(last_breq), 32'(e.breq));
                    chk("memout",     memOut, e.mout);
                    chk("memex",      {31'd0, memEx}, {31'd0, e.mex});
                end
                stall_len = 0;
                last_breq = 0;
            end else begin
                chk("memex_pulse", {31'd0, memEx}, 32'd0);
            end
            prev_stall = stall;
        end
    end

    // Issue one access, act as the bus slave (ack in BUSY cycle k; k outside
    // 1..TO means no ack), and predict the outcome from the access rules.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int k, input logic [31:0] rdata);
        exp_t e;
        logic valid;
        int   cyc;
        bit   done;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; exeOut = addr; rd2 = wd; busAck = 1'b0;
        valid = (addr[1:0] == 2'b00) && (addr <= CAP);
        e.we = wr; e.addr = addr; e.wdata = wd;
        if (!valid) begin
            e.breq = 0; e.stl = 1; e.mex = 1'b1; model_mem = 32'd0;
        end else if (k >= 1 && k <= TO) begin
            e.breq = k; e.stl = 1 + k; e.mex = 1'b0;
            if (!wr) model_mem = rdata;
        end else begin
            e.breq = TO; e.stl = 1 + TO; e.mex = 1'b1; model_mem = 32'd0;
        end
        e.mout = model_mem;
        sb.push_back(e);
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (busReq) begin
                cyc++;
                busAck   = (cyc == k);
                busRData = (cyc == k) ? rdata : $urandom;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
        MemRead = 1'b0; MemWrite = 1'b0; busAck = 1'b0;
        exeOut = $urandom; rd2 = $urandom;
    endtask

    // Idle cycles with stray acks: nothing may stall, request or change memOut.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
            busAck = 1'($urandom_range(0, 1)); busRData = $urandom;
            @(negedge clk);
            chk("idle_stall",  {31'd0, stall},  32'd0);
            chk("idle_busreq", {31'd0, busReq}, 32'd0);
            chk("idle_memout", memOut, model_mem);
        end
        @(posedge clk); #1;
        busAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        exeOut = 32'd0; rd2 = 32'd0; busAck = 1'b0; busRData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memout",  memOut,   32'd0);
        chk("rst_busreq",  {31'd0, busReq}, 32'd0);
        chk("rst_buswe",   {31'd0, busWe},  32'd0);
        chk("rst_busaddr", busAddr,  32'd0);
        chk("rst_wdata",   busWData, 32'd0);
        chk("rst_memex",   {31'd0, memEx},  32'd0);
        chk("rst_stall",   {31'd0, stall},  32'd0);
        reset = 1'b0;

        // Directed cases
        do_op(1'b1, 1'b0, 32'h40,     32'h0,    3,  32'hDEADBEEF);
        do_op(1'b0, 1'b1, 32'h10,     32'h1234, 1,  32'h0BAD0BAD);
        do_op(1'b1, 1'b0, 32'h42,     32'h0,    1,  32'h11111111);
        do_op(1'b1, 1'b0, 32'h10000,  32'h0,    1,  32'h22222222);
        do_op(1'b1, 1'b0, 32'hFFFC,   32'h0,    2,  32'h0000FFFC);
        do_op(1'b1, 1'b0, 32'hFFFF,   32'h0,    2,  32'h33333333);
        do_op(1'b1, 1'b0, 32'h80,     32'h0,    99, 32'h44444444);
        do_op(1'b1, 1'b0, 32'h84,     32'h0,    TO, 32'hA5A5A5A5);

        // Reset in the 2nd BUSY cycle, between clock edges
        @(posedge clk); #1;
        MemRead = 1'b1; exeOut = 32'h100; rd2 = 32'h0;
        sb.push_back('{1'b0, 32'h100, 32'h0, 10, 11, 32'h0, 1'b0});
        cyc = 0;
        for (int i = 0; i < 5 && cyc < 2; i++) begin
            @(posedge clk); #1;
            if (busReq) cyc++;
        end
        chk("pre_reset_busy", 32'(cyc), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busreq", {31'd0, busReq}, 32'd0);
        chk("midrst_stall",  {31'd0, stall},  32'd0);
        chk("midrst_memout", memOut, 32'd0);
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_mem = 32'd0;
        do_op(1'b1, 1'b0, 32'h8,  32'h0,  2, 32'hCAFEF00D);

        // Both controls set: a write; then idle with stray acks
        do_op(1'b1, 1'b1, 32'h20, 32'h55, 2, 32'h66666666);
        idle(5);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            int          kind, rw, k;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            rw   = $urandom_range(0, 2);
            k    = $urandom_range(1, TO + 2);
            a    = {16'd0, 14'($urandom_range(0, 16'h3fff)), 2'b00};
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = 32'h10000 + 32'($urandom_range(0, 32'hffff));
            do_op(rw != 1, rw != 0, a, $urandom, k, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
